// File: rtl/nts_tx_auth_writer_pkg.sv
// NTS shared definitions: authenticator writer FSM states, TX word
// size and address/count widths, common to TX writer and RX verifier.
package nts_tx_auth_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG_HI,
        ST_TAG_LO,
        ST_RAM_READ,
        ST_RAM_CAPTURE,
        ST_RAM_WRITE
    } nts_auth_state_t;

    localparam int TX_ADDR_WIDTH  = 8;
    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DATA_WIDTH = 64;
    localparam int BYTE_CNT_WIDTH = 10;
    localparam int WORD_BYTES     = 8;

    // 64-bit TX word size code
    localparam logic [2:0] TX_WORDSIZE = 3'd3;

    // RAM copies move whole 64-bit words only, and never zero of them.
    function automatic logic copy_len_bad(
        input logic [BYTE_CNT_WIDTH-1:0] bytes
    );
        return (bytes == '0) || (bytes[2:0] != 3'd0);
    endfunction

endpackage

// File: rtl/nts_tx_auth_writer.sv
// NTS TX authenticator writer: copies a 128-bit SIV tag or a run of
// local RAM words into the TX buffer as 64-bit writes.
//
// Ports:
//   i_clk, i_areset_n           clock, async active-low reset
//   o_busy, o_error             FSM not idle; rejected-op pulse
//   i_op_copy_tag/i_op_copy_ram op starts (tag has priority)
//   i_tag, i_ram_addr,
//   i_tx_addr, i_tx_bytes       op arguments, sampled on start
//   o_ram_en/o_ram_addr,
//   i_ram_rdata                 local RAM read port (1-cycle latency)
//   i_tx_wait                   TX stall
//   o_tx_wr_en, o_tx_addr,
//   o_tx_wordsize, o_tx_wr_data TX write port
module nts_tx_auth_writer
    import nts_tx_auth_writer_pkg::*;
#(
    parameter int TX_PORT_WIDTH = 64,
    parameter int ADDR_WIDTH    = TX_ADDR_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_areset_n,
    output logic                      o_busy,
    output logic                      o_error,
    input  logic                      i_op_copy_tag,
    input  logic                      i_op_copy_ram,
    input  logic [127:0]              i_tag,
    input  logic [RAM_ADDR_WIDTH-1:0] i_ram_addr,
    input  logic [ADDR_WIDTH+2:0]     i_tx_addr,
    input  logic [BYTE_CNT_WIDTH-1:0] i_tx_bytes,
    output logic                      o_ram_en,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
    input  logic [RAM_DATA_WIDTH-1:0] i_ram_rdata,
    input  logic                      i_tx_wait,
    output logic                      o_tx_wr_en,
    output logic [ADDR_WIDTH+2:0]     o_tx_addr,
    output logic [2:0]                o_tx_wordsize,
    output logic [TX_PORT_WIDTH-1:0]  o_tx_wr_data
);

    localparam int TXA_W = ADDR_WIDTH + 3;

    nts_auth_state_t state_q;
    nts_auth_state_t state_d;

    logic [RAM_DATA_WIDTH-1:0] data_q;
    logic [RAM_DATA_WIDTH-1:0] tag_lo_q;
    logic [TXA_W-1:0]          tx_addr_q;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
    logic [BYTE_CNT_WIDTH-1:0] bytes_q;
    logic                      error_q;

    logic start_tag;
    logic start_ram;
    logic reject;
    logic ram_en;
    logic wr_state;
    logic tx_fire;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_tag = 1'b0;
        start_ram = 1'b0;
        reject    = 1'b0;
        ram_en    = 1'b0;
        wr_state  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_op_copy_tag) begin
                    start_tag = 1'b1;
                    state_d   = ST_TAG_HI;
                end else if (i_op_copy_ram) begin
                    if (copy_len_bad(i_tx_bytes)) begin
                        reject = 1'b1;
                    end else begin
                        start_ram = 1'b1;
                        state_d   = ST_RAM_READ;
                    end
                end
            end
            ST_TAG_HI: begin
                wr_state = 1'b1;
                if (!i_tx_wait) state_d = ST_TAG_LO;
            end
            ST_TAG_LO: begin
                wr_state = 1'b1;
                if (!i_tx_wait) state_d = ST_IDLE;
            end
            ST_RAM_READ: begin
                ram_en  = 1'b1;
                state_d = ST_RAM_CAPTURE;
            end
            ST_RAM_CAPTURE: begin
                state_d = ST_RAM_WRITE;
            end
            ST_RAM_WRITE: begin
                wr_state = 1'b1;
                if (!i_tx_wait) begin
                    // last word when only one word's worth remains
                    if (bytes_q == BYTE_CNT_WIDTH'(WORD_BYTES))
                        state_d = ST_IDLE;
                    else
                        state_d = ST_RAM_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_fire = wr_state && !i_tx_wait;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            data_q     <= '0;
            tag_lo_q   <= '0;
            tx_addr_q  <= '0;
            ram_addr_q <= '0;
            bytes_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= reject;
            if (start_tag) begin
                data_q    <= i_tag[127:64];
                tag_lo_q  <= i_tag[63:0];
                tx_addr_q <= i_tx_addr;
            end
            if (start_ram) begin
                ram_addr_q <= i_ram_addr;
                tx_addr_q  <= i_tx_addr;
                bytes_q    <= i_tx_bytes;
            end
            if (state_q == ST_RAM_CAPTURE) begin
                data_q <= i_ram_rdata;
            end
            if (tx_fire) begin
                // address wraps naturally at the register width
                tx_addr_q <= tx_addr_q + TXA_W'(WORD_BYTES);
                if (state_q == ST_TAG_HI) begin
                    data_q <= tag_lo_q;
                end
                if (state_q == ST_RAM_WRITE) begin
                    ram_addr_q <= ram_addr_q + 1'b1;
                    bytes_q    <= bytes_q - BYTE_CNT_WIDTH'(WORD_BYTES);
                end
            end
        end
    end

    // Address/data are presented for the whole write state, so they stay
    // stable across TX stalls; they are zero everywhere else.
    always_comb begin
        o_tx_wr_data = '0;
        if (wr_state) o_tx_wr_data[RAM_DATA_WIDTH-1:0] = data_q;
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_error       = error_q;
    assign o_ram_en      = ram_en;
    assign o_ram_addr    = ram_en ? ram_addr_q : '0;
    assign o_tx_wr_en    = tx_fire;
    assign o_tx_addr     = wr_state ? tx_addr_q : '0;
    assign o_tx_wordsize = TX_WORDSIZE;

endmodule

// File: tb/tb_nts_tx_auth_writer.sv
// Testbench for nts_tx_auth_writer: scoreboard of expected TX writes
// and RAM reads, checked scenario by scenario.
module tb_nts_tx_auth_writer;

    typedef logic [74:0] wr_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         busy, error;
    logic         op_tag, op_ram;
    logic [127:0] tag;
    logic [7:0]   ram_addr_in;
    logic [10:0]  tx_addr_in;
    logic [9:0]   tx_bytes;
    logic         ram_en;
    logic [7:0]   ram_addr;
    logic [63:0]  ram_rdata;
    logic         tx_wait;
    logic         wr_en;
    logic [10:0]  tx_addr;
    logic [2:0]   wordsize;
    logic [63:0]  wr_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [256];

    wr_t        obs_wr  [1024];
    int         obs_cyc [1024];
    logic [7:0] obs_rd  [1024];
    int obs_n  = 0;
    int rd_n   = 0;
    int busy_n = 0;
    int err_n  = 0;
    int cyc    = 0;

    wr_t        exp_q    [$];
    logic [7:0] exp_rd_q [$];
    int wr_idx = 0;
    int rd_idx = 0;

    always #5 clk = ~clk;

    nts_tx_auth_writer dut (
        .i_clk         (clk),
        .i_areset_n    (rst_n),
        .o_busy        (busy),
        .o_error       (error),
        .i_op_copy_tag (op_tag),
        .i_op_copy_ram (op_ram),
        .i_tag         (tag),
        .i_ram_addr    (ram_addr_in),
        .i_tx_addr     (tx_addr_in),
        .i_tx_bytes    (tx_bytes),
        .o_ram_en      (ram_en),
        .o_ram_addr    (ram_addr),
        .i_ram_rdata   (ram_rdata),
        .i_tx_wait     (tx_wait),
        .o_tx_wr_en    (wr_en),
        .o_tx_addr     (tx_addr),
        .o_tx_wordsize (wordsize),
        .o_tx_wr_data  (wr_data)
    );

    always @(posedge clk) begin
        cyc++;
        if (ram_en) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (wr_en && obs_n < 1024) begin
            obs_wr[obs_n]  = {tx_addr, wr_data};
            obs_cyc[obs_n] = cyc;
            obs_n++;
        end
        if (ram_en && rd_n < 1024) begin
            obs_rd[rd_n] = ram_addr;
            rd_n++;
        end
        if (busy)  busy_n++;
        if (error) err_n++;
    end

    task automatic start_op(input logic t, input logic r,
                            input logic [127:0] tg,
                            input logic [7:0] ra,
                            input logic [10:0] ta,
                            input logic [9:0] nb);
        @(posedge clk); #1;
        tag = tg; ram_addr_in = ra; tx_addr_in = ta; tx_bytes = nb;
        op_tag = t; op_ram = r;
        @(posedge clk); #1;
        op_tag = 1'b0; op_ram = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op_tag = 0; op_ram = 0; tag = '0; ram_addr_in = 0;
        tx_addr_in = 0; tx_bytes = 0; tx_wait = 0;
        #1;
        checks++;
        if ({busy, error, ram_en, ram_addr, wr_en, tx_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b err=%b ren=%b ra=%h wen=%b ta=%h d=%h required all 0",
                     busy, error, ram_en, ram_addr, wr_en, tx_addr, wr_data);
        end
        checks++;
        if (wordsize !== 3'd3) begin
            errors++;
            $display("FAIL reset_wordsize: got %0d required 3", wordsize);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_copy_tag();
        bit to;
        int b0;
        wr_t e;
        b0 = busy_n;
        exp_q.push_back({11'h040, 64'h0011223344556677});
        exp_q.push_back({11'h048, 64'h8899AABBCCDDEEFF});
        start_op(1, 0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 8'd0, 11'h040, 10'd0);
        wait_idle(50, to);
        checks++;
        if (to) begin errors++; $display("FAIL tag_timeout: got busy required idle"); end
        checks++;
        if (busy_n - b0 != 2) begin
            errors++;
            $display("FAIL tag_busy: got %0d cycles required 2", busy_n - b0);
        end
        checks++;
        if (obs_n < wr_idx + 2 || obs_cyc[wr_idx+1] - obs_cyc[wr_idx] != 1) begin
            errors++;
            $display("FAIL tag_consecutive: got writes=%0d required 2 back-to-back", obs_n - wr_idx);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_idx >= obs_n) begin
                errors++; $display("FAIL tag_write: got none required %h", e);
            end else begin
                if (obs_wr[wr_idx] !== e) begin
                    errors++; $display("FAIL tag_write: got %h required %h", obs_wr[wr_idx], e);
                end
                wr_idx++;
            end
        end
        checks++;
        if (obs_n != wr_idx || rd_n != rd_idx) begin
            errors++;
            $display("FAIL tag_extra: got %0d writes %0d reads required 0", obs_n - wr_idx, rd_n - rd_idx);
        end
        wr_idx = obs_n; rd_idx = rd_n;
    endtask

    task automatic test_copy_ram(input bit stall);
        bit to;
        int b0;
        wr_t e;
        logic [7:0] r;
        b0 = busy_n;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({11'(11'h100 + 8*i), mem[4+i]});
            exp_rd_q.push_back(8'(4 + i));
        end
        start_op(0, 1, '0, 8'd4, 11'h100, 10'd24);
        if (stall) begin
            repeat (5) @(posedge clk);
            #1 tx_wait = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++;
                if (wr_en !== 1'b0 || tx_addr !== 11'h108 || wr_data !== mem[5]) begin
                    errors++;
                    $display("FAIL stall_hold: got wen=%b a=%h d=%h required 0/108/%h",
                             wr_en, tx_addr, wr_data, mem[5]);
                end
            end
            @(posedge clk);
            #1 tx_wait = 1'b0;
        end else begin
            // an op while busy must be ignored
            @(posedge clk); #1;
            op_tag = 1'b1;
            @(posedge clk); #1;
            op_tag = 1'b0;
        end
        wait_idle(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL ram_timeout: got busy required idle"); end
        checks++;
        if (busy_n - b0 != (stall ? 14 : 9)) begin
            errors++;
            $display("FAIL ram_busy: got %0d cycles required %0d", busy_n - b0, stall ? 14 : 9);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_idx >= obs_n) begin
                errors++; $display("FAIL ram_write: got none required %h", e);
            end else begin
                if (obs_wr[wr_idx] !== e) begin
                    errors++; $display("FAIL ram_write: got %h required %h", obs_wr[wr_idx], e);
                end
                wr_idx++;
            end
        end
        while (exp_rd_q.size() > 0) begin
            r = exp_rd_q.pop_front();
            checks++;
            if (rd_idx >= rd_n || obs_rd[rd_idx] !== r) begin
                errors++;
                $display("FAIL ram_read: got %h required %h", rd_idx < rd_n ? obs_rd[rd_idx] : 8'hxx, r);
            end
            rd_idx++;
        end
        checks++;
        if (obs_n != wr_idx || rd_n != rd_idx) begin
            errors++;
            $display("FAIL ram_extra: got %0d writes %0d reads beyond required", obs_n - wr_idx, rd_n - rd_idx);
        end
        wr_idx = obs_n; rd_idx = rd_n;
    endtask

    task automatic test_reject();
        logic [9:0] lens [2];
        int e0, b0;
        lens[0] = 10'd12;
        lens[1] = 10'd0;
        for (int k = 0; k < 2; k++) begin
            e0 = err_n; b0 = busy_n;
            start_op(0, 1, '0, 8'd4, 11'h100, lens[k]);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (err_n - e0 != 1) begin
                errors++;
                $display("FAIL reject_error len=%0d: got %0d pulse cycles required 1", lens[k], err_n - e0);
            end
            checks++;
            if (obs_n != wr_idx || rd_n != rd_idx || busy_n != b0) begin
                errors++;
                $display("FAIL reject_quiet len=%0d: got wr=%0d rd=%0d busy=%0d required 0",
                         lens[k], obs_n - wr_idx, rd_n - rd_idx, busy_n - b0);
            end
        end
    endtask

    task automatic test_priority();
        bit to;
        wr_t e;
        exp_q.push_back({11'h020, 64'hFEDCBA9876543210});
        exp_q.push_back({11'h028, 64'h0F1E2D3C4B5A6978});
        start_op(1, 1, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 8'd4, 11'h020, 10'd24);
        wait_idle(50, to);
        checks++;
        if (to) begin errors++; $display("FAIL prio_timeout: got busy required idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_idx >= obs_n) begin
                errors++; $display("FAIL prio_write: got none required %h", e);
            end else begin
                if (obs_wr[wr_idx] !== e) begin
                    errors++; $display("FAIL prio_write: got %h required %h", obs_wr[wr_idx], e);
                end
                wr_idx++;
            end
        end
        checks++;
        if (obs_n != wr_idx || rd_n != rd_idx) begin
            errors++;
            $display("FAIL prio_extra: got %0d writes %0d reads required 0", obs_n - wr_idx, rd_n - rd_idx);
        end
        wr_idx = obs_n; rd_idx = rd_n;
    endtask

    task automatic test_reset_mid();
        int sw, sr;
        wr_t e;
        bit to;
        exp_q.push_back({11'h100, mem[4]});
        start_op(0, 1, '0, 8'd4, 11'h100, 10'd24);
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (wr_en !== 1'b1) begin
            errors++; $display("FAIL mid_precond: got wen=%b required 1", wr_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, error, ram_en, ram_addr, wr_en, tx_addr, wr_data} !== '0 || wordsize !== 3'd3) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b ren=%b wen=%b ta=%h d=%h ws=%0d required 0s ws=3",
                     busy, ram_en, wr_en, tx_addr, wr_data, wordsize);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        sw = obs_n; sr = rd_n;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs_n != sw || rd_n != sr || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_resume: got wr=%0d rd=%0d busy=%b required none", obs_n - sw, rd_n - sr, busy);
        end
        // first op right after release is accepted on the first clock
        rst_n = 1'b0;
        tag = 128'h11111111_22222222_33333333_44444444;
        tx_addr_in = 11'h200;
        op_tag = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_tag = 1'b0;
        exp_q.push_back({11'h200, 64'h1111111122222222});
        exp_q.push_back({11'h208, 64'h3333333344444444});
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b1 || tx_addr !== 11'h200) begin
            errors++;
            $display("FAIL first_op: got busy=%b wen=%b a=%h required 1/1/200", busy, wr_en, tx_addr);
        end
        wait_idle(50, to);
        checks++;
        if (to) begin errors++; $display("FAIL first_op_timeout: got busy required idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_idx >= obs_n) begin
                errors++; $display("FAIL mid_write: got none required %h", e);
            end else begin
                if (obs_wr[wr_idx] !== e) begin
                    errors++; $display("FAIL mid_write: got %h required %h", obs_wr[wr_idx], e);
                end
                wr_idx++;
            end
        end
        checks++;
        if (obs_n != wr_idx) begin
            errors++; $display("FAIL mid_extra: got %0d extra writes required 0", obs_n - wr_idx);
        end
        wr_idx = obs_n; rd_idx = rd_n;
    endtask

    task automatic test_wrap();
        bit to;
        wr_t e;
        logic [7:0] r;
        exp_q.push_back({11'h7F8, mem[255]});
        exp_q.push_back({11'h000, mem[0]});
        exp_rd_q.push_back(8'd255);
        exp_rd_q.push_back(8'd0);
        start_op(0, 1, '0, 8'd255, 11'h7F8, 10'd16);
        wait_idle(50, to);
        checks++;
        if (to) begin errors++; $display("FAIL wrap_timeout: got busy required idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_idx >= obs_n) begin
                errors++; $display("FAIL wrap_write: got none required %h", e);
            end else begin
                if (obs_wr[wr_idx] !== e) begin
                    errors++; $display("FAIL wrap_write: got %h required %h", obs_wr[wr_idx], e);
                end
                wr_idx++;
            end
        end
        while (exp_rd_q.size() > 0) begin
            r = exp_rd_q.pop_front();
            checks++;
            if (rd_idx >= rd_n || obs_rd[rd_idx] !== r) begin
                errors++;
                $display("FAIL wrap_read: got %h required %h", rd_idx < rd_n ? obs_rd[rd_idx] : 8'hxx, r);
            end
            rd_idx++;
        end
        checks++;
        if (err_n != 0 + err_n - 0 || obs_n != wr_idx) begin
            errors++; $display("FAIL wrap_extra: got %0d extra writes required 0", obs_n - wr_idx);
        end
        wr_idx = obs_n; rd_idx = rd_n;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {24'hDA7A00, 8'(i), 24'h5EED00, 8'(255 - i)};
        end
        ram_rdata = '0;
        test_reset();
        test_copy_tag();
        test_copy_ram(1'b0);
        test_copy_ram(1'b1);
        test_reject();
        test_priority();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nts_tx_auth_writer.md
NTS_TX_AUTH_WRITER -- requirements
Module: nts_tx_auth_writer

Interface
REQ-001 Parameters SHALL be: TX_PORT_WIDTH, default 64, TX write data width; ADDR_WIDTH, default 8, TX buffer word-address width (byte address = ADDR_WIDTH+3 bits).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low (i_clk, i_areset_n).
REQ-003 i_clk  in  1  clock.
REQ-004 i_areset_n  in  1  async reset, active low.
REQ-005 o_busy  out  1  high whenever state is not IDLE.
REQ-006 o_error  out  1  one-cycle pulse when an op is rejected.
REQ-007 i_op_copy_tag  in  1  start op: write the 128-bit i_tag to TX.
REQ-008 i_op_copy_ram  in  1  start op: copy i_tx_bytes from local RAM to TX.
REQ-009 i_tag  in  128  SIV tag, sampled on op start.
REQ-010 i_ram_addr  in  8  first local RAM word address, sampled on op start.
REQ-011 i_tx_addr  in  ADDR_WIDTH+3  TX byte address of the first write, sampled on op start.
REQ-012 i_tx_bytes  in  10  byte count for copy_ram, sampled on op start.
REQ-013 o_ram_en  out  1  local RAM read enable; data valid exactly one cycle later.
REQ-014 o_ram_addr  out  8  local RAM word address.
REQ-015 i_ram_rdata  in  64  local RAM read data.
REQ-016 i_tx_wait  in  1  TX buffer stall; no write may be issued while high.
REQ-017 o_tx_wr_en  out  1  TX write strobe.
REQ-018 o_tx_addr  out  ADDR_WIDTH+3  TX byte address.
REQ-019 o_tx_wordsize  out  3  constant 3 (64-bit).
REQ-020 o_tx_wr_data  out  TX_PORT_WIDTH  TX write data.

Function
REQ-021 States SHALL be IDLE, TAG_HI, TAG_LO, RAM_READ, RAM_CAPTURE, RAM_WRITE.
REQ-022 In IDLE, i_op_copy_tag SHALL take priority over i_op_copy_ram; ops asserted while busy SHALL be ignored.
REQ-023 copy_tag: IDLE->TAG_HI, writing i_tag[127:64] at i_tx_addr; then TAG_LO, writing i_tag[63:0] at i_tx_addr+8; then IDLE.
REQ-024 copy_ram SHALL be rejected (o_error pulse, stay IDLE, no RAM or TX access) when i_tx_bytes is 0 or i_tx_bytes[2:0] is not 0.
REQ-025 Accepted copy_ram: IDLE->RAM_READ; RAM_READ asserts o_ram_en for one cycle and goes to RAM_CAPTURE; RAM_CAPTURE registers i_ram_rdata and goes to RAM_WRITE.
REQ-026 RAM_WRITE SHALL issue one TX write of the captured word when i_tx_wait is low, then advance the TX address by 8 and the RAM address by 1 and decrement the remaining count by 8.
REQ-027 After a RAM_WRITE write, the FSM SHALL go to IDLE if the remaining count is 0, else to RAM_READ.
REQ-028 o_tx_wr_en SHALL be combinational: high only in TAG_HI, TAG_LO or RAM_WRITE with i_tx_wait low. A write-state SHALL hold, with address and data stable, while i_tx_wait is high.
REQ-029 The TX address SHALL wrap modulo 2^(ADDR_WIDTH+3), and the RAM address SHALL wrap modulo 256, without error.
REQ-030 When not writing, o_tx_addr and o_tx_wr_data SHALL be 0; when o_ram_en is low, o_ram_addr SHALL be 0.
REQ-031 The maximum copy is 1016 bytes (127 words), taking 3 cycles per word plus TX stall cycles.

Reset
REQ-032 Assertion of i_areset_n low SHALL immediately force IDLE, clear all registers and drive every output to 0, except o_tx_wordsize, which stays at 3; this includes resets mid-operation.
REQ-033 An operation interrupted by reset SHALL NOT resume; the first op SHALL be accepted on the first clock after reset deassertion.

Structure
REQ-034 The state encoding, the wordsize constant, and the TX/RAM address widths SHALL live in a shared NTS package that is also used by the RX-side verifier.
REQ-035 The block SHALL be a single module with no sub-modules; the local RAM is external, accessed only through the o_ram_* and i_ram_rdata ports.

Verification
REQ-036 copy_tag with i_tag=0x00112233_44556677_8899AABB_CCDDEEFF, i_tx_addr=0x040, i_tx_wait=0 -> writes 0x0011223344556677@0x040 and 0x8899AABBCCDDEEFF@0x048 on consecutive cycles; o_busy is high for 2 cycles.
REQ-037 copy_ram with i_ram_addr=4, i_tx_addr=0x100, i_tx_bytes=24, RAM[4..6]=A,B,C -> TX writes A@0x100, B@0x108, C@0x110; 9 busy cycles.
REQ-038 The same copy_ram with i_tx_wait held high for 5 cycles during the second RAM_WRITE -> write order and data are unchanged, o_tx_addr/o_tx_wr_data are held stable, and 14 busy cycles.
REQ-039 copy_ram with i_tx_bytes=12, and separately with i_tx_bytes=0 -> one o_error pulse each, and no o_ram_en or o_tx_wr_en activity.
REQ-040 Simultaneous copy_tag and copy_ram -> only the tag is written; deassert i_areset_n during the second copy_ram word -> all outputs drop to 0 at once and no further writes occur after release.
REQ-041 copy_ram with i_ram_addr=255, i_tx_addr=0x7F8 (ADDR_WIDTH=8), 16 bytes -> RAM reads at 255 then 0, and TX writes at 0x7F8 then 0x000.
